ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage, fed directly by the ID_EX pipeline register outputs. It executes MIPS MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO against private HI/LO registers. It raises a stall to the hazard logic whenever a multiply/divide-class instruction reaches EX while a previous multiply or divide is still iterating.

## Interface
- No parameters. Fixed 32-bit datapath, 32 iterations.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  ID_EX slot holds a real instruction; 0 for a bubble or flushed slot.
- ALUOp_in  in  2  from ID_EX; 2'b10 marks R-type.
- IF_ID_funct_in  in  6  funct field from ID_EX.
- reg_read_data_1_in  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- reg_read_data_2_in  in  32  rt operand: multiplier or divisor.
- muldiv_stall_out  out  1  hold IF/ID/ID_EX and insert a bubble into EX_MEM this cycle.
- mf_data_out  out  32  HI for MFHI, LO for MFLO, otherwise 0; combinational.
- hi_out, lo_out  out  32  current HI and LO registers, for debug and trace.

## Operation
- md-op: valid_in=1, ALUOp_in=2'b10, and funct is one of:
  - 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU
- States: IDLE, MUL, DIV, FIX.
- IDLE behaviour:
  - MULT/MULTU: latch operands and go to MUL; cnt=0.
  - DIV/DIVU: latch operands and go to DIV; cnt=0.
  - MTHI/MTLO: write rs to HI/LO at this edge.
  - Non-md instructions: ignored.
- Signed ops:
  - Operate on the absolute values of the operands.
  - Latch neg_q = sign(rs) XOR sign(rt) and neg_r = sign(rs).
- MUL: shift-add, one multiplier bit per cycle into a 64-bit accumulator; cnt increments; after cnt=31, go to FIX.
- DIV: restoring division, one quotient bit per cycle; 32-bit remainder with 33-bit trial subtract; after cnt=31, go to FIX.
- FIX:
  - Apply signs: product is negated when neg_q; quotient is negated when neg_q; remainder is negated when neg_r.
  - Write {HI,LO} = product, or LO = quotient and HI = remainder.
  - Go to IDLE.
- Divide by zero needs no special case and keeps the full latency. Result: LO=0xFFFFFFFF and HI=|rs|, with sign fix applied to HI only.
- Signed overflow 0x80000000 / -1 gives LO=0x80000000, HI=0.
- muldiv_stall_out = (state != IDLE) && md-op. Non-md instructions flow past a busy unit.
- A stalled md-op is held by upstream and is accepted on the first IDLE cycle.

## Timing
- Reset (rst=0), asynchronous:
  - state=IDLE, cnt=0, HI=LO=0, operand and accumulator registers cleared.
  - muldiv_stall_out=0 immediately.
- Reset mid-operation: the in-flight op is abandoned and HI/LO read 0.
- Multiply/divide accepted at edge E:
  - Iterations run at edges E+1..E+32.
  - FIX writes HI/LO at edge E+33.
  - state is IDLE after E+33.
- An md-op presented in the cycle right after the accept stalls for 33 cycles, then executes and sees the new HI/LO.
- MTHI/MTLO take effect at their accept edge. An MFHI/MFLO in the next cycle reads the new value.
- MFHI/MFLO in IDLE: mf_data_out is valid in the same cycle, with no stall.
- A new md-op is never accepted in the cycle FIX writes, because state != IDLE.
- valid_in=0 never starts, stalls or writes anything.

## Structure
- Shared package muldiv_pkg holds:
  - funct constants FUNCT_MFHI..FUNCT_DIVU
  - ALUOP_RTYPE
  - state enum
  - constant MD_ITERS=32
- One sub-module, muldiv_step: combinational single-iteration shift-add / trial-subtract slice, selected by a mul/div flag.
- The FSM, counter and HI/LO registers stay in ex_muldiv.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: at edge E+33, HI=0xFFFFFFFE and LO=0x00000001; an MFLO issued at E+1 stalls 33 cycles, then returns 0x00000001.
- MULT -3 × 7: HI=0xFFFFFFFF and LO=0xFFFFFFEB. DIV -7 / 2: LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- DIVU 0x12345678 / 0: LO=0xFFFFFFFF and HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000 and HI=0.
- MTLO 0xCAFEBABE followed by MFLO: mf_data_out=0xCAFEBABE in the next cycle, muldiv_stall_out never asserted. The same MTLO with valid_in=0 leaves LO unchanged.
- While MUL is busy, an R-type ADD (funct 0x20) and a bubble pass with stall=0. An MFHI asserts stall until the unit is IDLE.
- Assert rst=0 asynchronously at cycle 10 of a DIV: stall drops immediately, HI=LO=0, state=IDLE. A MULT 2×3 after release gives LO=6 at accept+33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and helpers for the EX-stage multiply/divide unit.
// Funct codes follow the MIPS R-type encoding for the HI/LO instruction group.
package muldiv_pkg;

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;
   localparam logic [5:0] FUNCT_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam int unsigned MD_ITERS = 32;
   localparam int unsigned CNT_W    = $clog2(MD_ITERS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITERS - 1);

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} md_state_e;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // Magnitude of a two's-complement value when the op is signed; 0x80000000 maps to itself.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? neg32(v) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring trial-subtract for divide, on a shared 64-bit accumulator.
module muldiv_step (
   input  logic        div_i,
   input  logic [63:0] acc_i,
   input  logic [31:0] op_i,
   output logic [63:0] acc_o
);

   logic [32:0] sum;
   logic [32:0] trial;
   logic [32:0] diff;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide:   acc = {remainder, dividend bits / quotient bits shifted in from the right}.
   always_comb begin
      sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, op_i} : 33'd0);
      trial = acc_i[63:31];
      diff  = trial - {1'b0, op_i};
      acc_o = {sum, acc_i[31:1]};
      if (div_i) begin
         if (!diff[32]) begin
            acc_o = {diff[31:0], acc_i[30:0], 1'b1};
         end else begin
            acc_o = {trial[31:0], acc_i[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MIPS multiply/divide unit with private HI/LO, sitting in EX and
// stalling the front of the pipe while an operation is iterating.
module ex_muldiv
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [1:0]  ALUOp_in,
   input  logic [5:0]  IF_ID_funct_in,
   input  logic [31:0] reg_read_data_1_in,
   input  logic [31:0] reg_read_data_2_in,
   output logic        muldiv_stall_out,
   output logic [31:0] mf_data_out,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      op_q, op_d;
   logic [63:0]      acc_q, acc_d;
   logic             neg_quot_q, neg_quot_d;
   logic             neg_rem_q, neg_rem_d;
   logic             div_q, div_d;

   logic        md_op;
   logic        signed_op;
   logic [63:0] step_acc;
   logic [63:0] prod_fix;

   muldiv_step u_step (
      .div_i (div_q),
      .acc_i (acc_q),
      .op_i  (op_q),
      .acc_o (step_acc)
   );

   always_comb begin
      md_op = valid_in && (ALUOp_in == ALUOP_RTYPE) &&
              (IF_ID_funct_in inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
                                      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
      signed_op = (IF_ID_funct_in == FUNCT_MULT) || (IF_ID_funct_in == FUNCT_DIV);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      op_d       = op_q;
      acc_d      = acc_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      div_d      = div_q;
      prod_fix   = neg_quot_q ? (~acc_q + 64'd1) : acc_q;

      unique case (state_q)
         StIdle: begin
            if (md_op) begin
               unique case (IF_ID_funct_in)
                  FUNCT_MTHI: hi_d = reg_read_data_1_in;
                  FUNCT_MTLO: lo_d = reg_read_data_1_in;
                  FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                     op_d       = abs32(reg_read_data_2_in, signed_op);
                     acc_d      = {32'h0, abs32(reg_read_data_1_in, signed_op)};
                     neg_quot_d = signed_op &&
                                  (reg_read_data_1_in[31] ^ reg_read_data_2_in[31]);
                     neg_rem_d  = signed_op && reg_read_data_1_in[31];
                     div_d      = IF_ID_funct_in[1];
                     cnt_d      = '0;
                     state_d    = IF_ID_funct_in[1] ? StDiv : StMul;
                  end
                  default: ;
               endcase
            end
         end
         StMul, StDiv: begin
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (div_q) begin
               // A zero divisor leaves an all-ones quotient that is never sign-corrected.
               lo_d = (neg_quot_q && (op_q != 32'h0)) ? neg32(acc_q[31:0]) : acc_q[31:0];
               hi_d = neg_rem_q ? neg32(acc_q[63:32]) : acc_q[63:32];
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         op_q       <= '0;
         acc_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         op_q       <= op_d;
         acc_q      <= acc_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         div_q      <= div_d;
      end
   end

   always_comb begin
      muldiv_stall_out = (state_q != StIdle) && md_op;
      mf_data_out      = 32'h0;
      if (md_op && (IF_ID_funct_in == FUNCT_MFHI)) begin
         mf_data_out = hi_q;
      end else if (md_op && (IF_ID_funct_in == FUNCT_MFLO)) begin
         mf_data_out = lo_q;
      end
      hi_out = hi_q;
      lo_out = lo_q;
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a vector table of mul/div results plus
// hand-written sequences for stall timing, MT/MF forwarding and async reset.
module tb_ex_muldiv;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [1:0]  ALUOp_in;
   logic [5:0]  IF_ID_funct_in;
   logic [31:0] reg_read_data_1_in;
   logic [31:0] reg_read_data_2_in;
   logic        muldiv_stall_out;
   logic [31:0] mf_data_out;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic [5:0]  funct;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[10];

   ex_muldiv dut (
      .clk                (clk),
      .rst                (rst),
      .valid_in           (valid_in),
      .ALUOp_in           (ALUOp_in),
      .IF_ID_funct_in     (IF_ID_funct_in),
      .reg_read_data_1_in (reg_read_data_1_in),
      .reg_read_data_2_in (reg_read_data_2_in),
      .muldiv_stall_out   (muldiv_stall_out),
      .mf_data_out        (mf_data_out),
      .hi_out             (hi_out),
      .lo_out             (lo_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic issue(input logic v, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
      valid_in           = v;
      ALUOp_in           = ALUOP_RTYPE;
      IF_ID_funct_in     = f;
      reg_read_data_1_in = a;
      reg_read_data_2_in = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic count_stall(output int n);
      n = 0;
      while (muldiv_stall_out && n < 100) begin
         n++;
         tick();
      end
   endtask

   initial begin
      logic [31:0] prev_hi;
      logic [31:0] prev_lo;
      int          stalls;

      vecs[0] = '{"multu_ff",   FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1] = '{"mult_m3x7",  FUNCT_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2] = '{"div_m7d2",   FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{"divu_zero",  FUNCT_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
      vecs[4] = '{"div_ovf",    FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5] = '{"multu_2p32", FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[6] = '{"divu_100d7", FUNCT_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      vecs[7] = '{"div_7dm2",   FUNCT_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[8] = '{"mult_min2",  FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[9] = '{"div_m5d0",   FUNCT_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};

      // Reset state
      rst = 1'b0;
      issue(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
      tick();
      tick();
      chk("reset_hi", hi_out, 32'h0);
      chk("reset_lo", lo_out, 32'h0);
      chk("reset_stall", {31'h0, muldiv_stall_out}, 32'h0);
      #2 rst = 1'b1;

      // MTLO / MFLO forwarding and bubble suppression
      tick();
      issue(1'b1, FUNCT_MTLO, 32'hCAFEBABE, 32'h0);
      #1 chk("mtlo_stall", {31'h0, muldiv_stall_out}, 32'h0);
      tick();
      issue(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
      #1 chk("mflo_after_mtlo", mf_data_out, 32'hCAFEBABE);
      chk("mflo_stall", {31'h0, muldiv_stall_out}, 32'h0);
      issue(1'b0, FUNCT_MTLO, 32'h12345678, 32'h0);
      tick();
      chk("mtlo_bubble_lo", lo_out, 32'hCAFEBABE);
      issue(1'b1, FUNCT_MTHI, 32'h0BADF00D, 32'h0);
      tick();
      issue(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
      #1 chk("mfhi_after_mthi", mf_data_out, 32'h0BADF00D);
      prev_hi = 32'h0BADF00D;
      prev_lo = 32'hCAFEBABE;

      // Vector table: accept at E, results must appear at E+33 and not before
      for (int i = 0; i < 10; i++) begin
         issue(1'b1, vecs[i].funct, vecs[i].rs, vecs[i].rt);
         #1 chk({vecs[i].name, "_accept_stall"}, {31'h0, muldiv_stall_out}, 32'h0);
         tick();
         issue(1'b0, 6'h0, 32'h0, 32'h0);
         repeat (32) tick();
         chk({vecs[i].name, "_early_hi"}, hi_out, prev_hi);
         chk({vecs[i].name, "_early_lo"}, lo_out, prev_lo);
         tick();
         chk({vecs[i].name, "_hi"}, hi_out, vecs[i].hi);
         chk({vecs[i].name, "_lo"}, lo_out, vecs[i].lo);
         issue(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
         #1 chk({vecs[i].name, "_mflo"}, mf_data_out, vecs[i].lo);
         issue(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
         #1 chk({vecs[i].name, "_mfhi"}, mf_data_out, vecs[i].hi);
         issue(1'b0, 6'h0, 32'h0, 32'h0);
         prev_hi = vecs[i].hi;
         prev_lo = vecs[i].lo;
         tick();
      end

      // MFLO right behind a MULTU stalls 33 cycles, then reads the new LO
      issue(1'b1, FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      issue(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
      #1 count_stall(stalls);
      chk("mflo_stall_cycles", stalls, 32'd33);
      chk("mflo_after_mul", mf_data_out, 32'h00000001);
      issue(1'b0, 6'h0, 32'h0, 32'h0);
      tick();

      // Non-md traffic passes a busy unit; MFHI waits for it
      issue(1'b1, FUNCT_MULT, 32'hFFFFFFFD, 32'h00000007);
      tick();
      issue(1'b1, 6'h20, 32'h1, 32'h2);
      #1 chk("busy_add_stall", {31'h0, muldiv_stall_out}, 32'h0);
      issue(1'b0, FUNCT_MFHI, 32'h0, 32'h0);
      #1 chk("busy_bubble_stall", {31'h0, muldiv_stall_out}, 32'h0);
      tick();
      issue(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
      #1 chk("busy_mfhi_stall", {31'h0, muldiv_stall_out}, 32'h1);
      count_stall(stalls);
      chk("busy_mfhi_cycles", stalls, 32'd32);
      chk("busy_mfhi_data", mf_data_out, 32'hFFFFFFFF);
      issue(1'b0, 6'h0, 32'h0, 32'h0);
      tick();

      // Asynchronous reset in the middle of a DIV
      issue(1'b1, FUNCT_DIV, 32'h00000064, 32'h00000007);
      tick();
      issue(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
      repeat (9) tick();
      chk("div_busy_stall", {31'h0, muldiv_stall_out}, 32'h1);
      #2 rst = 1'b0;
      #1 chk("rst_mid_stall", {31'h0, muldiv_stall_out}, 32'h0);
      chk("rst_mid_hi", hi_out, 32'h0);
      chk("rst_mid_lo", lo_out, 32'h0);
      chk("rst_mid_mf", mf_data_out, 32'h0);
      issue(1'b0, 6'h0, 32'h0, 32'h0);
      #1 rst = 1'b1;
      tick();
      issue(1'b1, FUNCT_MULT, 32'h00000002, 32'h00000003);
      #1 chk("post_rst_accept", {31'h0, muldiv_stall_out}, 32'h0);
      tick();
      issue(1'b0, 6'h0, 32'h0, 32'h0);
      repeat (32) tick();
      chk("post_rst_early_lo", lo_out, 32'h0);
      tick();
      chk("post_rst_lo", lo_out, 32'h6);
      chk("post_rst_hi", hi_out, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
